// File: rtl/spectrum_sweep_ctrl_pkg.sv
// spectrum_pkg: shared types and default sizes for the spectrum sweep sequencer.
// Provides the sweep FSM state enum, default parameter values and a bin-result record.
package spectrum_pkg;

    localparam int NUM_BINS_DEF  = 16;
    localparam int BIN_W_DEF     = 4;
    localparam int N_SAMPLES_DEF = 64;
    localparam int CNT_W_DEF     = 8;
    localparam int MAG_W_DEF     = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        FINISH,
        WAIT,
        EMIT,
        FEND
    } state_t;

    typedef struct packed {
        logic [BIN_W_DEF-1:0] bin;
        logic [MAG_W_DEF-1:0] mag;
    } bin_result_t;

endpackage

// File: rtl/spectrum_sweep_ctrl_peak_tracker.sv
// spectrum_peak_tracker: running frame peak with clear/update/commit controls.
// Ports: clk, rst (sync, active-high); clear zeroes the running peak; update offers
// (bin, mag) and is taken only if mag is strictly greater, so ties keep the earlier bin;
// commit copies the running peak to peak_bin/peak_mag, which hold until the next commit.
module spectrum_peak_tracker
    import spectrum_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic             commit,
    input  logic [BIN_W-1:0] bin,
    input  logic [MAG_W-1:0] mag,
    output logic [BIN_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag
);

    logic [BIN_W-1:0] run_bin;
    logic [MAG_W-1:0] run_mag;

    // commit and clear may coincide at a continuous frame boundary: the old
    // running peak is published while the running copy restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_bin  <= '0;
            run_mag  <= '0;
            peak_bin <= '0;
            peak_mag <= '0;
        end else begin
            if (commit) begin
                peak_bin <= run_bin;
                peak_mag <= run_mag;
            end
            if (clear) begin
                run_bin <= '0;
                run_mag <= '0;
            end else if (update && mag > run_mag) begin
                run_bin <= bin;
                run_mag <= mag;
            end
        end
    end

endmodule

// File: rtl/spectrum_sweep_ctrl.sv
// spectrum_sweep_ctrl: steps the single-bin engine through every bin and streams results.
// Ports: clk, rst (sync, active-high); start/continuous sweep control; sample_valid from
// the front-end; eng_clear/eng_bin/eng_sample_en/eng_finish drive the engine, eng_done/
// eng_mag return its magnitude; out_valid/out_ready/out_bin/out_mag stream results;
// peak_bin/peak_mag hold the last completed frame peak; busy and frame_done report status.
module spectrum_sweep_ctrl
    import spectrum_pkg::*;
#(
    parameter int NUM_BINS  = NUM_BINS_DEF,
    parameter int BIN_W     = BIN_W_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAG_W     = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             sample_valid,
    output logic             eng_clear,
    output logic [BIN_W-1:0] eng_bin,
    output logic             eng_sample_en,
    output logic             eng_finish,
    input  logic             eng_done,
    input  logic [MAG_W-1:0] eng_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out_bin,
    output logic [MAG_W-1:0] out_mag,
    output logic [BIN_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic             busy,
    output logic             frame_done
);

    state_t           state;
    logic [BIN_W-1:0] bin;
    logic [CNT_W-1:0] cnt;
    logic             last_bin;
    logic             last_sample;

    assign eng_bin       = bin;
    assign eng_sample_en = (state == ACCUM) && sample_valid;
    assign last_bin      = bin == BIN_W'(NUM_BINS - 1);
    assign last_sample   = cnt == CNT_W'(N_SAMPLES - 1);

    // Pulse outputs are set on the transition into their state so they are
    // high exactly for the one cycle spent there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bin        <= '0;
            cnt        <= '0;
            eng_clear  <= 1'b0;
            eng_finish <= 1'b0;
            out_valid  <= 1'b0;
            out_bin    <= '0;
            out_mag    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            eng_clear  <= 1'b0;
            eng_finish <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    bin       <= '0;
                    eng_clear <= 1'b1;
                    busy      <= 1'b1;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= ACCUM;
                end
                ACCUM: if (sample_valid) begin
                    cnt <= cnt + 1'b1;
                    if (last_sample) begin
                        eng_finish <= 1'b1;
                        state      <= FINISH;
                    end
                end
                FINISH: state <= WAIT;
                WAIT: if (eng_done) begin
                    out_mag   <= eng_mag;
                    out_bin   <= bin;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (last_bin) begin
                        frame_done <= 1'b1;
                        state      <= FEND;
                    end else begin
                        bin       <= bin + 1'b1;
                        eng_clear <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                FEND: if (continuous) begin
                    bin       <= '0;
                    eng_clear <= 1'b1;
                    state     <= CLEAR;
                end else begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    spectrum_peak_tracker #(
        .BIN_W(BIN_W),
        .MAG_W(MAG_W)
    ) u_peak (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == IDLE && start) || (state == FEND && continuous)),
        .update  (state == EMIT && out_ready),
        .commit  (state == FEND),
        .bin     (out_bin),
        .mag     (out_mag),
        .peak_bin(peak_bin),
        .peak_mag(peak_mag)
    );

endmodule

// File: tb/tb_spectrum_sweep_ctrl.sv
// tb_spectrum_sweep_ctrl: directed self-checking bench for spectrum_sweep_ctrl (4 bins, 4 samples).
module tb_spectrum_sweep_ctrl;

    localparam int NB = 4;
    localparam int NS = 4;

    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic       continuous = 0;
    logic       sample_valid = 0;
    logic       eng_clear;
    logic [1:0] eng_bin;
    logic       eng_sample_en;
    logic       eng_finish;
    logic       eng_done = 0;
    logic [7:0] eng_mag = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [1:0] out_bin;
    logic [7:0] out_mag;
    logic [1:0] peak_bin;
    logic [7:0] peak_mag;
    logic       busy;
    logic       frame_done;

    spectrum_sweep_ctrl #(
        .NUM_BINS(NB), .BIN_W(2), .N_SAMPLES(NS), .CNT_W(2), .MAG_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .sample_valid(sample_valid), .eng_clear(eng_clear), .eng_bin(eng_bin),
        .eng_sample_en(eng_sample_en), .eng_finish(eng_finish), .eng_done(eng_done),
        .eng_mag(eng_mag), .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_mag(out_mag), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // engine model: magnitude from table, returned two cycles after eng_finish
    logic [7:0] mags [4] = '{5, 15, 25, 35};
    logic       d1 = 0;
    always @(posedge clk) begin
        d1       <= eng_finish;
        eng_done <= d1;
        eng_mag  <= d1 ? mags[eng_bin] : 8'd0;
    end

    // sample source: 1 = every cycle, 3 = every third cycle
    int sv_mode = 1;
    int ph = 0;
    initial forever begin
        @(posedge clk);
        #1;
        ph = (ph == 2) ? 0 : ph + 1;
        sample_valid = (sv_mode == 1) || (sv_mode == 3 && ph == 0);
    end

    // observation recorder
    logic [1:0] clr_bins [$];
    logic [1:0] res_bin [$];
    logic [7:0] res_mag [$];
    int en_cnt [4];
    int fd_cnt = 0;
    int gate_err = 0;
    bit in_wait = 0;
    always @(negedge clk) begin
        if (rst) in_wait = 0;
        else begin
            if (eng_clear) clr_bins.push_back(eng_bin);
            if (eng_finish) in_wait = 1;
            if (out_valid) in_wait = 0;
            if (eng_sample_en) begin
                en_cnt[eng_bin]++;
                if (!sample_valid || eng_clear || eng_finish || out_valid || in_wait) gate_err++;
            end
            if (out_valid && out_ready) begin
                res_bin.push_back(out_bin);
                res_mag.push_back(out_mag);
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic clear_mon();
        clr_bins.delete();
        res_bin.delete();
        res_mag.delete();
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        fd_cnt = 0;
        gate_err = 0;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1; break; end
        end
    endtask

    task automatic wait_finish_on(input logic [1:0] b, output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (eng_finish && eng_bin == b) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (peak_mag !== 8'd0 || peak_bin !== 2'd0) begin errors++; $display("FAIL reset_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
        checks++; if (eng_clear !== 1'b0 || eng_finish !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_pulses got %0b%0b%0b want 000", eng_clear, eng_finish, frame_done); end
    endtask

    task automatic test_single_sweep();
        bit ok;
        int lat;
        clear_mon();
        mags = '{5, 15, 25, 35};
        start_pulse();
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        checks++; if (lat != 9) begin errors++; $display("FAIL first_latency got %0d want 9", lat); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got 0 want 1"); end
        @(posedge clk); #1;
        checks++; if (clr_bins.size() != 4) begin errors++; $display("FAIL single_clears got %0d want 4", clr_bins.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (clr_bins[i] !== 2'(i)) begin errors++; $display("FAIL single_clear_bin%0d got %0d want %0d", i, clr_bins[i], i); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (en_cnt[i] != NS) begin errors++; $display("FAIL single_en_bin%0d got %0d want %0d", i, en_cnt[i], NS); end
        end
        checks++; if (res_mag.size() != 4) begin errors++; $display("FAIL single_results got %0d want 4", res_mag.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (res_bin[i] !== 2'(i) || res_mag[i] !== 8'(10 * i + 5)) begin errors++; $display("FAIL single_result%0d got %0d/%0d want %0d/%0d", i, res_bin[i], res_mag[i], i, 10 * i + 5); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL single_frame_done got %0d want 1", fd_cnt); end
        checks++; if (peak_bin !== 2'd3 || peak_mag !== 8'd35) begin errors++; $display("FAIL single_peak got %0d/%0d want 3/35", peak_bin, peak_mag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", busy); end
        checks++; if (gate_err != 0) begin errors++; $display("FAIL single_gating got %0d want 0", gate_err); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        mags = '{5, 15, 25, 35};
        start_pulse();
        wait_finish_on(2'd1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_finish_timeout got 0 want 1"); end
        @(posedge clk); #1 out_ready = 0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout got 0 want 1"); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got %0b want 1", i, out_valid); end
            checks++; if (out_bin !== 2'd1 || out_mag !== 8'd15) begin errors++; $display("FAIL bp_data_c%0d got %0d/%0d want 1/15", i, out_bin, out_mag); end
            checks++; if (eng_clear !== 1'b0) begin errors++; $display("FAIL bp_early_clear_c%0d got %0b want 0", i, eng_clear); end
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %0b want 0", out_valid); end
        checks++; if (eng_clear !== 1'b1 || eng_bin !== 2'd2) begin errors++; $display("FAIL bp_clear_bin2 got %0b/%0d want 1/2", eng_clear, eng_bin); end
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got 0 want 1"); end
        checks++; if (res_mag.size() != 4) begin errors++; $display("FAIL bp_results got %0d want 4", res_mag.size()); end
        else begin
            checks++; if (res_bin[1] !== 2'd1 || res_mag[1] !== 8'd15) begin errors++; $display("FAIL bp_result1 got %0d/%0d want 1/15", res_bin[1], res_mag[1]); end
        end
        @(posedge clk); #1;
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL bp_frame_done got %0d want 1", fd_cnt); end
    endtask

    task automatic test_sparse();
        bit ok;
        clear_mon();
        sv_mode = 3;
        mags = '{5, 15, 25, 35};
        start_pulse();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (eng_clear && eng_bin == 2'd1) begin ok = 1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL sparse_clear1_timeout got 0 want 1"); end
        start_pulse();
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sparse_timeout got 0 want 1"); end
        @(posedge clk); #1;
        sv_mode = 1;
        checks++; if (clr_bins.size() != 4) begin errors++; $display("FAIL sparse_clears got %0d want 4", clr_bins.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (clr_bins[i] !== 2'(i)) begin errors++; $display("FAIL sparse_clear_bin%0d got %0d want %0d", i, clr_bins[i], i); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (en_cnt[i] != NS) begin errors++; $display("FAIL sparse_en_bin%0d got %0d want %0d", i, en_cnt[i], NS); end
        end
        checks++; if (gate_err != 0) begin errors++; $display("FAIL sparse_gating got %0d want 0", gate_err); end
        checks++; if (fd_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL sparse_end got %0d/%0b want 1/0", fd_cnt, busy); end
    endtask

    task automatic test_peak_ties();
        bit ok;
        clear_mon();
        mags = '{9, 20, 20, 3};
        start_pulse();
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ties_timeout got 0 want 1"); end
        @(posedge clk); #1;
        checks++; if (peak_bin !== 2'd1 || peak_mag !== 8'd20) begin errors++; $display("FAIL ties_peak got %0d/%0d want 1/20", peak_bin, peak_mag); end
    endtask

    task automatic test_continuous();
        bit ok;
        clear_mon();
        continuous = 1;
        mags = '{7, 7, 7, 7};
        start_pulse();
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_f1_timeout got 0 want 1"); end
        mags = '{1, 2, 3, 4};
        @(posedge clk); #1;
        checks++; if (peak_bin !== 2'd0 || peak_mag !== 8'd7) begin errors++; $display("FAIL cont_peak1 got %0d/%0d want 0/7", peak_bin, peak_mag); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy got %0b want 1", busy); end
        @(negedge clk);
        checks++; if (eng_clear !== 1'b1 || eng_bin !== 2'd0) begin errors++; $display("FAIL cont_restart got %0b/%0d want 1/0", eng_clear, eng_bin); end
        continuous = 0;
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_f2_timeout got 0 want 1"); end
        @(posedge clk); #1;
        checks++; if (peak_bin !== 2'd3 || peak_mag !== 8'd4) begin errors++; $display("FAIL cont_peak2 got %0d/%0d want 3/4", peak_bin, peak_mag); end
        checks++; if (fd_cnt != 2 || busy !== 1'b0) begin errors++; $display("FAIL cont_end got %0d/%0b want 2/0", fd_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        mags = '{5, 15, 25, 35};
        start_pulse();
        wait_finish_on(2'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_finish_timeout got 0 want 1"); end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        clear_mon();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rmid_state got %0b/%0b want 0/0", busy, out_valid); end
        checks++; if (peak_mag !== 8'd0 || peak_bin !== 2'd0) begin errors++; $display("FAIL rmid_peak got %0d/%0d want 0/0", peak_bin, peak_mag); end
        repeat (6) @(negedge clk);
        checks++; if (res_mag.size() != 0 || fd_cnt != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_late_done got %0d/%0d/%0b/%0b want 0/0/0/0", res_mag.size(), fd_cnt, out_valid, busy); end
        start_pulse();
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got 0 want 1"); end
        @(posedge clk); #1;
        checks++; if (clr_bins.size() != 4 || res_mag.size() != 4) begin errors++; $display("FAIL rmid_counts got %0d/%0d want 4/4", clr_bins.size(), res_mag.size()); end
        else begin
            checks++; if (clr_bins[0] !== 2'd0 || res_bin[0] !== 2'd0 || res_mag[0] !== 8'd5) begin errors++; $display("FAIL rmid_first got %0d/%0d/%0d want 0/0/5", clr_bins[0], res_bin[0], res_mag[0]); end
        end
        checks++; if (peak_bin !== 2'd3 || peak_mag !== 8'd35) begin errors++; $display("FAIL rmid_peak_after got %0d/%0d want 3/35", peak_bin, peak_mag); end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_backpressure();
        test_sparse();
        test_peak_ties();
        test_continuous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_sweep_ctrl.md
Name: spectrum_sweep_ctrl

Overview:
Sequencer for the tiny-spectrum bin engine (Goertzel-style single-bin accumulator). It steps the engine through every frequency bin, gates N input samples into each bin, collects each bin magnitude, and streams (bin, magnitude) pairs to the output formatter over valid/ready. It also tracks the frame peak. It sits between the sample front-end and the uo_out formatter inside tt_um_kentrane_tinyspectrum.

Parameters:
NUM_BINS, 16, bins per sweep (power of 2, 2..16)
BIN_W, 4, width of bin index (log2 NUM_BINS)
N_SAMPLES, 64, samples accumulated per bin (2..256)
CNT_W, 8, sample counter width (holds N_SAMPLES-1)
MAG_W, 8, magnitude width

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a sweep; sampled only in IDLE
continuous  in  1  1 = restart at bin 0 after frame end; sampled at frame end
sample_valid  in  1  new front-end sample this cycle
eng_clear  out  1  1-cycle pulse: clear engine state, load eng_bin coefficient
eng_bin  out  BIN_W  bin index driven to engine, stable from CLEAR through WAIT
eng_sample_en  out  1  = sample_valid while in ACCUM, else 0 (combinational)
eng_finish  out  1  1-cycle pulse: compute magnitude
eng_done  in  1  engine magnitude valid (1 cycle)
eng_mag  in  MAG_W  engine magnitude, qualified by eng_done
out_valid  out  1  bin result available
out_ready  in  1  formatter accepts
out_bin  out  BIN_W  bin of current result
out_mag  out  MAG_W  magnitude of current result
peak_bin  out  BIN_W  bin of largest magnitude in last completed frame
peak_mag  out  MAG_W  largest magnitude in last completed frame
busy  out  1  state != IDLE
frame_done  out  1  1-cycle pulse after last bin accepted

Behaviour:
- Reset: state IDLE. All outputs 0, bin/sample counters 0, running peak 0. Reset mid-sweep abandons the frame with no frame_done, and out_valid drops in the same cycle as reset.
- States: IDLE, CLEAR, ACCUM, FINISH, WAIT, EMIT, FEND.
- IDLE: when start=1, set bin=0 and go to CLEAR next cycle. Clear the running peak (run_mag=0, run_bin=0).
- CLEAR: eng_clear=1 for exactly 1 cycle. Set cnt=0, then go to ACCUM.
- ACCUM: each sample_valid increments cnt and is forwarded as eng_sample_en. When sample_valid arrives with cnt==N_SAMPLES-1, go to FINISH. Exactly N_SAMPLES enables per bin. No timeout.
- FINISH: eng_finish=1 for 1 cycle, then go to WAIT. sample_valid is ignored and not forwarded outside ACCUM.
- WAIT: on eng_done, latch out_mag=eng_mag and out_bin=bin. Go to EMIT with out_valid=1 the following cycle. eng_done outside WAIT is ignored.
- EMIT: hold out_valid, out_bin and out_mag stable until out_ready=1. On the handshake cycle:
  - Update the peak if out_mag > run_mag, strictly greater. Ties keep the earlier (lower) bin.
  - If bin==NUM_BINS-1, go to FEND. Otherwise increment bin and go to CLEAR.
  - out_valid deasserts the next cycle.
- FEND: frame_done=1 for 1 cycle. Copy the running peak to peak_bin/peak_mag; these hold until the next FEND or reset. If continuous=1, set bin=0, clear the running peak, and go to CLEAR. Otherwise go to IDLE.
- start outside IDLE is ignored.
- Minimum latency, start to first out_valid: 1 (CLEAR) + N_SAMPLES accepted samples + 1 (FINISH) + engine latency + 1.
- Bin counter never wraps mid-frame. Wrap to 0 happens only via FEND.

Decomposition:
- Package spectrum_pkg: state enum (IDLE..FEND), default NUM_BINS/N_SAMPLES/MAG_W localparams, and a bin-result struct {bin, mag}.
- One sub-module is natural: spectrum_peak_tracker. It holds the running peak with clear/update/commit controls and the strict-greater compare, and drives peak_bin/peak_mag.
- The FSM and counters stay in the top.

Test Plan:
1. Single sweep: N_SAMPLES=4, NUM_BINS=4, sample_valid every cycle, engine returns mag = 10*bin+5 two cycles after eng_finish, out_ready=1.
   -> Exactly 4 eng_clear pulses with eng_bin 0,1,2,3 and 4 eng_sample_en per bin. Outputs (0,5), (1,15), (2,25), (3,35). One frame_done; peak_bin=3, peak_mag=35; busy=0 afterwards.
2. Backpressure: out_ready low for 7 cycles on bin 1.
   -> out_valid stays 1 and out_bin=1, out_mag=15 stay stable all 7 cycles. eng_clear for bin 2 appears only after the handshake.
3. Sparse samples and ignored inputs: sample_valid on every 3rd cycle, plus start pulsed mid-sweep.
   -> Still exactly 4 enables per bin. Sweep is not restarted. eng_sample_en=0 in CLEAR/FINISH/WAIT/EMIT.
4. Peak ties: mags 9,20,20,3.
   -> peak_bin=1, peak_mag=20.
5. Continuous mode: continuous=1 for two frames with mags 7,7,7,7 then 1,2,3,4.
   -> Two frame_done pulses. After frame 1: peak_bin=0, peak_mag=7. After frame 2: peak_bin=3, peak_mag=4 (running peak cleared between frames). Frame 2 begins with eng_clear on bin 0 the cycle after FEND.
6. Reset mid-operation: rst asserted during WAIT of bin 2.
   -> Next cycle: IDLE, busy=0, out_valid=0, peak_mag=0, no frame_done. A late eng_done is ignored. A new start begins at bin 0.
